// File: rtl/opal_rx_ctrl_pkg.sv
// Shared definitions for the OPAL receive controller: controller state encoding,
// receiver state_watch codes and fixed phase lengths.
package opal_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_RECV    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_GAP     = 3'd4,
    ST_DELIVER = 3'd5,
    ST_FAULT   = 3'd6
  } ctrl_state_e;

  // Receiver state_watch codes the controller reacts to
  localparam logic [3:0] RX_WAIT = 4'd4;
  localparam logic [3:0] RX_FAIL = 4'd5;

  // Cycles rx_enable stays high after WAIT is seen, so var1..var16 get latched
  localparam int HOLD_CYCLES = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/opal_rx_ctrl.sv
// OPAL receive controller: arms on i_sync, enables the receiver for one frame,
// waits for WAIT/FAIL or a timeout, then delivers the frame or records a fault.
module opal_rx_ctrl
  import opal_rx_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int GAP_CYCLES     = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_run,
  input  logic                 i_sync,
  output logic                 rx_enable,
  input  logic [3:0]           rx_state,
  output logic                 o_valid,
  input  logic                 i_ack,
  output logic [CNT_WIDTH-1:0] o_frame_cnt,
  output logic [7:0]           o_err_cnt,
  output logic                 o_timeout,
  output logic                 o_busy,
  output logic [2:0]           o_state
);

  localparam int TO_W   = cnt_w(TIMEOUT_CYCLES);
  localparam int GAP_W  = cnt_w(GAP_CYCLES);
  localparam int HOLD_W = cnt_w(HOLD_CYCLES);

  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  ctrl_state_e          state_q, state_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                 from_fault_q, from_fault_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]           err_cnt_q, err_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      from_fault_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      from_fault_q <= from_fault_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    from_fault_d = from_fault_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (i_run) state_d = ST_ARM;
      end

      // Dropping i_run wins over a coincident sync so a stop request is never missed
      ST_ARM: begin
        if (!i_run) begin
          state_d = ST_IDLE;
        end else if (i_sync) begin
          state_d  = ST_RECV;
          to_cnt_d = '0;
        end
      end

      ST_RECV: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (rx_state == RX_FAIL || to_cnt_q == TO_LAST) begin
          state_d = ST_FAULT;
        end else if (rx_state == RX_WAIT) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end

      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d      = ST_GAP;
          gap_cnt_d    = '0;
          from_fault_d = 1'b0;
          frame_cnt_d  = frame_cnt_q + CNT_WIDTH'(1);
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      // The gap lets the receiver fall back to IDLE before the next frame
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (!from_fault_q) state_d = ST_DELIVER;
          else if (i_run)    state_d = ST_ARM;
          else               state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      ST_DELIVER: begin
        if (i_ack) state_d = i_run ? ST_ARM : ST_IDLE;
      end

      ST_FAULT: begin
        state_d      = ST_GAP;
        gap_cnt_d    = '0;
        from_fault_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_enable   = (state_q == ST_RECV) || (state_q == ST_HOLD);
  assign o_valid     = (state_q == ST_DELIVER);
  assign o_timeout   = (state_q == ST_FAULT);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_state     = state_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;

endmodule
